// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings,
// opcodes and datapath select constants.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_IF        = 4'd1,
      S_ID        = 4'd2,
      S_R_EXE     = 4'd3,
      S_ALU_WB    = 4'd4,
      S_LR_ADDR   = 4'd5,
      S_SR_ADDR   = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_STORE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd12,
      S_ERROR     = 4'd13
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADDI = 4'd2;
   localparam logic [3:0] OP_LR   = 4'd3;
   localparam logic [3:0] OP_SR   = 4'd4;
   localparam logic [3:0] OP_BNE  = 4'd5;
   localparam logic [3:0] OP_LI   = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [1:0] PC_SELECT_ALU     = 2'd0;
   localparam logic [1:0] PC_SELECT_ALU_BUF = 2'd1;
   localparam logic [1:0] PC_SELECT_JUMP    = 2'd2;
   localparam logic [1:0] PC_SELECT_RESET   = 2'd3;

   localparam logic       ALU_SRC_A_PC  = 1'b0;
   localparam logic       ALU_SRC_A_REG = 1'b1;
   localparam logic [1:0] ALU_SRC_B_REG = 2'd0;
   localparam logic [1:0] ALU_SRC_B_ONE = 2'd1;
   localparam logic [1:0] ALU_SRC_B_IMM = 2'd2;

   localparam logic DATA_SELECT_ALU = 1'b0;
   localparam logic DATA_SELECT_MEM = 1'b1;

   localparam int unsigned ALU_OP_ADD = 0;
   localparam int unsigned ALU_OP_SUB = 1;

   // States that wait on the memory handshake and are covered by the timeout
   function automatic logic is_wait_state(input state_t s);
      return (s == S_IF) || (s == S_MEM_READ) || (s == S_MEM_STORE);
   endfunction

endpackage

// File: rtl/ctrl_mem_wait.sv
// Memory wait counter: counts stalled cycles in a memory-wait state and
// flags a timeout when MEM_TIMEOUT cycles pass without mem_ready.
module ctrl_mem_wait #(
   parameter int TIMEOUT_W   = 4,
   parameter int MEM_TIMEOUT = 12
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [TIMEOUT_W-1:0] LIMIT =
      TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

   logic [TIMEOUT_W-1:0] count;

   // Clear on entry to a wait state, otherwise count stalled cycles up to saturation
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (active && !mem_ready && (count != '1)) begin
         count <= count + TIMEOUT_W'(1);
      end
   end

   // A ready in the final allowed cycle suppresses the timeout
   assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle CPU control FSM for the single-bus datapath.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_v2
   import ctrl_pkg::*;
#(
   parameter int WIDTH_OPCODE = 4,
   parameter int ALU_OP_W     = 2,
   parameter int TIMEOUT_W    = 4,
   parameter int MEM_TIMEOUT  = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH_OPCODE-1:0] opcode,
   input  logic                    zero,
   input  logic                    mem_ready,
   output logic                    IR_Write,
   output logic                    MemToReg,
   output logic                    Mem_Read_not_Write,
   output logic                    Mem_Select,
   output logic                    mem_req,
   output logic [1:0]              PC_Source,
   output logic                    pc_write_enable,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [ALU_OP_W-1:0]     ALUop,
   output logic                    RegWrite,
   output logic                    halted,
   output logic                    error
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]             cycle_cnt,
   output logic [31:0]             retire_cnt
`endif
);

   state_t state, next_state;
   logic   timeout;
   logic   wait_clear;

   function automatic logic op_is(input logic [WIDTH_OPCODE-1:0] op, input logic [3:0] code);
      return op == WIDTH_OPCODE'(code);
   endfunction

   // The counter restarts whenever the FSM moves into a memory-wait state
   assign wait_clear = (next_state != state) && is_wait_state(next_state);

   ctrl_mem_wait #(
      .TIMEOUT_W   (TIMEOUT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait (
      .clk       (clk),
      .reset     (reset),
      .clear     (wait_clear),
      .active    (is_wait_state(state)),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) state <= S_RESET;
      else        state <= next_state;
   end

   // Next-state and datapath control decode
   always_comb begin
      next_state         = state;
      IR_Write           = 1'b0;
      MemToReg           = DATA_SELECT_ALU;
      Mem_Read_not_Write = 1'b1;
      Mem_Select         = 1'b0;
      mem_req            = 1'b0;
      PC_Source          = PC_SELECT_ALU;
      pc_write_enable    = 1'b0;
      alu_src_a          = ALU_SRC_A_PC;
      alu_src_b          = ALU_SRC_B_REG;
      ALUop              = ALU_OP_W'(ALU_OP_ADD);
      RegWrite           = 1'b0;
      halted             = 1'b0;
      error              = 1'b0;
      case (state)
         S_RESET: begin
            PC_Source       = PC_SELECT_RESET;
            pc_write_enable = 1'b1;
            next_state      = S_IF;
         end
         S_IF: begin
            mem_req   = 1'b1;
            alu_src_a = ALU_SRC_A_PC;
            alu_src_b = ALU_SRC_B_ONE;
            if (mem_ready) begin
               IR_Write        = 1'b1;
               pc_write_enable = 1'b1;
               PC_Source       = PC_SELECT_ALU;
               next_state      = S_ID;
            end else if (timeout) begin
               next_state = S_ERROR;
            end
         end
         S_ID: begin
            alu_src_a = ALU_SRC_A_PC;
            alu_src_b = ALU_SRC_B_IMM;
            if (op_is(opcode, OP_NOP))
               next_state = S_IF;
            else if (op_is(opcode, OP_ADD) || op_is(opcode, OP_SUB) ||
                     op_is(opcode, OP_ADDI) || op_is(opcode, OP_LI))
               next_state = S_R_EXE;
            else if (op_is(opcode, OP_LR))
               next_state = S_LR_ADDR;
            else if (op_is(opcode, OP_SR))
               next_state = S_SR_ADDR;
            else if (op_is(opcode, OP_BNE) || op_is(opcode, OP_BEQ))
               next_state = S_BRANCH;
            else if (op_is(opcode, OP_JMP))
               next_state = S_JUMP;
            else if (op_is(opcode, OP_HALT))
               next_state = S_HALT;
            else
               next_state = S_ERROR;
         end
         S_R_EXE: begin
            alu_src_a = ALU_SRC_A_REG;
            if (op_is(opcode, OP_ADD) || op_is(opcode, OP_SUB))
               alu_src_b = ALU_SRC_B_REG;
            else
               alu_src_b = ALU_SRC_B_IMM;
            if (op_is(opcode, OP_SUB))
               ALUop = ALU_OP_W'(ALU_OP_SUB);
            next_state = S_ALU_WB;
         end
         S_ALU_WB: begin
            RegWrite   = 1'b1;
            MemToReg   = DATA_SELECT_ALU;
            next_state = S_IF;
         end
         S_LR_ADDR, S_SR_ADDR: begin
            alu_src_a  = ALU_SRC_A_REG;
            alu_src_b  = ALU_SRC_B_IMM;
            next_state = (state == S_LR_ADDR) ? S_MEM_READ : S_MEM_STORE;
         end
         S_MEM_READ: begin
            mem_req    = 1'b1;
            Mem_Select = 1'b1;
            if (mem_ready)    next_state = S_MEM_WB;
            else if (timeout) next_state = S_ERROR;
         end
         S_MEM_WB: begin
            RegWrite   = 1'b1;
            MemToReg   = DATA_SELECT_MEM;
            Mem_Select = 1'b1;
            next_state = S_IF;
         end
         S_MEM_STORE: begin
            mem_req            = 1'b1;
            Mem_Select         = 1'b1;
            Mem_Read_not_Write = 1'b0;
            if (mem_ready)    next_state = S_IF;
            else if (timeout) next_state = S_ERROR;
         end
         S_BRANCH: begin
            alu_src_a = ALU_SRC_A_REG;
            alu_src_b = ALU_SRC_B_REG;
            ALUop     = ALU_OP_W'(ALU_OP_SUB);
            if ((op_is(opcode, OP_BNE) && !zero) || (op_is(opcode, OP_BEQ) && zero)) begin
               pc_write_enable = 1'b1;
               PC_Source       = PC_SELECT_ALU_BUF;
            end
            next_state = S_IF;
         end
         S_JUMP: begin
            pc_write_enable = 1'b1;
            PC_Source       = PC_SELECT_JUMP;
            next_state      = S_IF;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         S_ERROR: begin
            error = 1'b1;
         end
         default: begin
            next_state = S_RESET;
         end
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   logic retire;

   assign retire = (next_state == S_IF) &&
                   ((state == S_ID) || (state == S_ALU_WB) || (state == S_MEM_WB) ||
                    (state == S_MEM_STORE) || (state == S_BRANCH) || (state == S_JUMP));

   // Active-cycle and retired-instruction counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if ((state != S_RESET) && (state != S_HALT) && (state != S_ERROR))
            cycle_cnt <= cycle_cnt + 32'd1;
         if (retire)
            retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Scoreboard bench for multicycle_ctrl_v2: the driver queues the expected
// output vector for every cycle it drives, the monitor checks it mid-cycle.
module tb_multicycle_ctrl_v2;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, mem_req;
   logic [1:0]  PC_Source;
   logic        pc_write_enable, alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  ALUop;
   logic        RegWrite, halted, error;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, retire_cnt;
`endif

   multicycle_ctrl_v2 dut (
      .clk                (clk),
      .reset              (reset),
      .opcode             (opcode),
      .zero               (zero),
      .mem_ready          (mem_ready),
      .IR_Write           (IR_Write),
      .MemToReg           (MemToReg),
      .Mem_Read_not_Write (Mem_Read_not_Write),
      .Mem_Select         (Mem_Select),
      .mem_req            (mem_req),
      .PC_Source          (PC_Source),
      .pc_write_enable    (pc_write_enable),
      .alu_src_a          (alu_src_a),
      .alu_src_b          (alu_src_b),
      .ALUop              (ALUop),
      .RegWrite           (RegWrite),
      .halted             (halted),
      .error              (error)
`ifdef CTRL_PERF_CNT_EN
      ,
      .cycle_cnt          (cycle_cnt),
      .retire_cnt         (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   // {IR_Write, MemToReg, RnW, Mem_Select, mem_req, PC_Source, pc_we, src_a, src_b, ALUop, RegWrite, halted, error}
   function automatic logic [15:0] mk(input bit ir, input bit m2r, input bit rnw, input bit msel,
                                      input bit mreq, input bit [1:0] pcs, input bit pcwe,
                                      input bit sa, input bit [1:0] sb, input bit [1:0] alu,
                                      input bit rw, input bit hlt, input bit err);
      return {ir, m2r, rnw, msel, mreq, pcs, pcwe, sa, sb, alu, rw, hlt, err};
   endfunction

   localparam logic [15:0] E_RESET    = mk(0,0,1,0,0,2'd3,1,0,2'd0,2'd0,0,0,0);
   localparam logic [15:0] E_IF_WAIT  = mk(0,0,1,0,1,2'd0,0,0,2'd1,2'd0,0,0,0);
   localparam logic [15:0] E_IF_RDY   = mk(1,0,1,0,1,2'd0,1,0,2'd1,2'd0,0,0,0);
   localparam logic [15:0] E_ID       = mk(0,0,1,0,0,2'd0,0,0,2'd2,2'd0,0,0,0);
   localparam logic [15:0] E_EXE_ADD  = mk(0,0,1,0,0,2'd0,0,1,2'd0,2'd0,0,0,0);
   localparam logic [15:0] E_EXE_SUB  = mk(0,0,1,0,0,2'd0,0,1,2'd0,2'd1,0,0,0);
   localparam logic [15:0] E_EXE_IMM  = mk(0,0,1,0,0,2'd0,0,1,2'd2,2'd0,0,0,0);
   localparam logic [15:0] E_ALU_WB   = mk(0,0,1,0,0,2'd0,0,0,2'd0,2'd0,1,0,0);
   localparam logic [15:0] E_ADDR     = mk(0,0,1,0,0,2'd0,0,1,2'd2,2'd0,0,0,0);
   localparam logic [15:0] E_MEM_RD   = mk(0,0,1,1,1,2'd0,0,0,2'd0,2'd0,0,0,0);
   localparam logic [15:0] E_MEM_WB   = mk(0,1,1,1,0,2'd0,0,0,2'd0,2'd0,1,0,0);
   localparam logic [15:0] E_MEM_ST   = mk(0,0,0,1,1,2'd0,0,0,2'd0,2'd0,0,0,0);
   localparam logic [15:0] E_BR_NT    = mk(0,0,1,0,0,2'd0,0,1,2'd0,2'd1,0,0,0);
   localparam logic [15:0] E_BR_T     = mk(0,0,1,0,0,2'd1,1,1,2'd0,2'd1,0,0,0);
   localparam logic [15:0] E_JUMP     = mk(0,0,1,0,0,2'd2,1,0,2'd0,2'd0,0,0,0);
   localparam logic [15:0] E_HALT     = mk(0,0,1,0,0,2'd0,0,0,2'd0,2'd0,0,1,0);
   localparam logic [15:0] E_ERR      = mk(0,0,1,0,0,2'd0,0,0,2'd0,2'd0,0,0,1);

   typedef struct {
      string       name;
      logic [15:0] exp;
      bit          chk_perf;
      logic [31:0] cyc;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   logic [15:0] act;
   int          checks   = 0;
   int          failures = 0;

   assign act = {IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, mem_req, PC_Source,
                 pc_write_enable, alu_src_a, alu_src_b, ALUop, RegWrite, halted, error};

   // Monitor: one queued expectation per driven cycle, checked on the falling edge
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         checks++;
         if (act !== cur.exp) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", cur.name, act, cur.exp);
         end
`ifdef CTRL_PERF_CNT_EN
         if (cur.chk_perf) begin
            checks++;
            if (cycle_cnt !== cur.cyc) begin
               failures++;
               $display("FAIL %s_cycle_cnt: got %0d expected %0d", cur.name, cycle_cnt, cur.cyc);
            end
            checks++;
            if (retire_cnt !== cur.ret) begin
               failures++;
               $display("FAIL %s_retire_cnt: got %0d expected %0d", cur.name, retire_cnt, cur.ret);
            end
         end
`endif
      end
   end

   // Drive one cycle of inputs and queue what the outputs must be in that cycle
   task automatic cyc(input string nm, input logic [3:0] op, input logic z, input logic rdy,
                      input logic [15:0] e);
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      sb_q.push_back('{nm, e, 1'b0, 32'd0, 32'd0});
      @(posedge clk);
      #1;
   endtask

   task automatic cycp(input string nm, input logic [3:0] op, input logic rdy,
                       input logic [15:0] e, input logic [31:0] c, input logic [31:0] r);
      opcode    = op;
      zero      = 1'b0;
      mem_ready = rdy;
      sb_q.push_back('{nm, e, 1'b1, c, r});
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input string nm, input logic [3:0] op, input logic [15:0] exe);
      cyc({nm, "_if"}, op, 1'b0, 1'b1, E_IF_RDY);
      cyc({nm, "_id"}, op, 1'b0, 1'b1, E_ID);
      cyc({nm, "_exe"}, op, 1'b0, 1'b1, exe);
      cyc({nm, "_wb"}, op, 1'b0, 1'b1, E_ALU_WB);
   endtask

   task automatic run_branch(input string nm, input logic [3:0] op, input logic z,
                             input logic [15:0] e);
      cyc({nm, "_if"}, op, z, 1'b1, E_IF_RDY);
      cyc({nm, "_id"}, op, z, 1'b1, E_ID);
      cyc({nm, "_br"}, op, z, 1'b1, e);
   endtask

   initial begin
      reset     = 1'b0;
      opcode    = 4'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cycp("reset_state", 4'd0, 1'b1, E_RESET, 32'd0, 32'd0);

      run_alu("add", 4'd1, E_EXE_ADD);
      run_alu("sub", 4'd7, E_EXE_SUB);
      run_alu("addi", 4'd2, E_EXE_IMM);
      run_alu("li", 4'd6, E_EXE_IMM);

      cyc("lr_if", 4'd3, 1'b0, 1'b1, E_IF_RDY);
      cyc("lr_id", 4'd3, 1'b0, 1'b1, E_ID);
      cyc("lr_addr", 4'd3, 1'b0, 1'b1, E_ADDR);
      for (int i = 0; i < 3; i++) cyc("lr_wait", 4'd3, 1'b0, 1'b0, E_MEM_RD);
      cyc("lr_rdy", 4'd3, 1'b0, 1'b1, E_MEM_RD);
      cyc("lr_wb", 4'd3, 1'b0, 1'b1, E_MEM_WB);

      cyc("sr_if", 4'd4, 1'b0, 1'b1, E_IF_RDY);
      cyc("sr_id", 4'd4, 1'b0, 1'b1, E_ID);
      cyc("sr_addr", 4'd4, 1'b0, 1'b1, E_ADDR);
      cyc("sr_wait", 4'd4, 1'b0, 1'b0, E_MEM_ST);
      cyc("sr_rdy", 4'd4, 1'b0, 1'b1, E_MEM_ST);

      run_branch("beq_z1", 4'd8, 1'b1, E_BR_T);
      run_branch("beq_z0", 4'd8, 1'b0, E_BR_NT);
      run_branch("bne_z1", 4'd5, 1'b1, E_BR_NT);
      run_branch("bne_z0", 4'd5, 1'b0, E_BR_T);

      cyc("jmp_if", 4'd9, 1'b0, 1'b1, E_IF_RDY);
      cyc("jmp_id", 4'd9, 1'b0, 1'b1, E_ID);
      cyc("jmp", 4'd9, 1'b0, 1'b1, E_JUMP);

      for (int i = 0; i < 3; i++) cyc("nop_if_wait", 4'd0, 1'b0, 1'b0, E_IF_WAIT);
      cyc("nop_if", 4'd0, 1'b0, 1'b1, E_IF_RDY);
      cyc("nop_id", 4'd0, 1'b0, 1'b1, E_ID);

      // Twelve stalled fetch cycles: the 12th edge enters ERROR
      for (int i = 0; i < 12; i++) cyc("to_if_wait", 4'd0, 1'b0, 1'b0, E_IF_WAIT);
      for (int i = 0; i < 3; i++) cyc("to_error", 4'd1, 1'b0, 1'b1, E_ERR);
      reset = 1'b0;
      cyc("to_err_rst", 4'd0, 1'b0, 1'b1, E_ERR);
      reset = 1'b1;
      cyc("to_reset", 4'd0, 1'b0, 1'b1, E_RESET);

      // Ready arrives in the 12th cycle: fetch completes, no error
      for (int i = 0; i < 11; i++) cyc("late_if_wait", 4'd0, 1'b0, 1'b0, E_IF_WAIT);
      cyc("late_if_rdy", 4'd0, 1'b0, 1'b1, E_IF_RDY);
      cyc("late_id", 4'd0, 1'b0, 1'b1, E_ID);

      cyc("ill_if", 4'd12, 1'b0, 1'b1, E_IF_RDY);
      cyc("ill_id", 4'd12, 1'b0, 1'b1, E_ID);
      for (int i = 0; i < 20; i++) cyc("ill_error", 4'd12, 1'b0, 1'b1, E_ERR);
      reset = 1'b0;
      cyc("ill_err_rst", 4'd12, 1'b0, 1'b1, E_ERR);
      reset = 1'b1;
      cycp("ill_reset", 4'd1, 1'b1, E_RESET, 32'd0, 32'd0);

      run_alu("h_add0", 4'd1, E_EXE_ADD);
      run_alu("h_add1", 4'd1, E_EXE_ADD);
      cyc("halt_if", 4'd15, 1'b0, 1'b1, E_IF_RDY);
      cyc("halt_id", 4'd15, 1'b0, 1'b1, E_ID);
      for (int i = 0; i < 5; i++) cycp("halted", 4'd15, 1'(i % 2), E_HALT, 32'd10, 32'd2);
      reset = 1'b0;
      cyc("halt_rst", 4'd15, 1'b0, 1'b1, E_HALT);
      reset = 1'b1;
      cyc("halt_reset", 4'd0, 1'b0, 1'b1, E_RESET);

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending %0d expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
Second-generation multicycle CPU control FSM. It sequences fetch, decode, execute, memory and writeback for the single-bus datapath. It generalises the first-generation controller with parametrised opcode and ALU-op widths, a memory ready/request handshake with timeout, SUB/BEQ/JMP/HALT instructions, and sticky error and halt status. It sits between the instruction register and the datapath mux, enable and ALU controls.

Parameters:
WIDTH_OPCODE, 4, opcode field width; must be at least 4.
ALU_OP_W, 2, ALU operation select width.
TIMEOUT_W, 4, width of the memory wait counter.
MEM_TIMEOUT, 12, wait cycles without mem_ready before entering ERROR; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
opcode  in  WIDTH_OPCODE  opcode from the IR.
zero  in  1  ALU result equals 0.
mem_ready  in  1  memory completes the current access this cycle.
IR_Write  out  1  load the IR.
MemToReg  out  1  0 = ALU buffer, 1 = memory data.
Mem_Read_not_Write  out  1  1 = read, 0 = write.
Mem_Select  out  1  data-memory access; 0 = instruction fetch.
mem_req  out  1  memory access request.
PC_Source  out  2  0 = ALU, 1 = ALU buffer, 2 = jump, 3 = reset vector.
pc_write_enable  out  1  PC load.
alu_src_a  out  1  0 = PC, 1 = register A.
alu_src_b  out  2  0 = register B, 1 = +1, 2 = immediate.
ALUop  out  ALU_OP_W  0 = ADD, 1 = SUB.
RegWrite  out  1  register-file write.
halted  out  1  HALT executed.
error  out  1  illegal opcode or memory timeout.

Behaviour:
- Output style: outputs are combinational from state, opcode, zero and mem_ready. Default every output to 0, except Mem_Read_not_Write = 1 and ALUop = ADD.
- Reset: while reset = 0, the next edge sets state = RESET and clears the wait counter. This applies mid-operation from any state, including HALT and ERROR.
- Reset-state outputs: PC_Source = 3, pc_write_enable = 1. All other outputs at default.
- RESET -> IF: unconditional.
- IF: mem_req = 1, Mem_Select = 0, alu_src_a = 0, alu_src_b = 1.
  - When mem_ready = 1: IR_Write = 1, pc_write_enable = 1, PC_Source = 0, go to ID.
  - Otherwise stay in IF with no writes.
- ID: ALU computes PC + immediate (alu_src_a = 0, alu_src_b = 2) for the branch target. No writes. Dispatch:
  - NOP -> IF
  - ADD, SUB, ADDI, LI -> R_EXE
  - LR -> LR_ADDR
  - SR -> SR_ADDR
  - BNE, BEQ -> BRANCH
  - JMP -> JUMP
  - HALT -> HALT
  - any other opcode -> ERROR
- R_EXE: alu_src_a = 1. alu_src_b = 0 for ADD/SUB, 2 for ADDI/LI. ALUop = SUB for SUB, otherwise ADD. Next state ALU_WB.
- ALU_WB: RegWrite = 1, MemToReg = 0, then IF.
- LR_ADDR / SR_ADDR: alu_src_a = 1, alu_src_b = 2, ADD. Next state MEM_READ or MEM_STORE respectively.
- MEM_READ: mem_req = 1, Mem_Select = 1, read. Advance to MEM_WB on mem_ready, otherwise hold.
- MEM_WB: RegWrite = 1, MemToReg = 1, Mem_Select = 1, then IF.
- MEM_STORE: mem_req = 1, Mem_Select = 1, Mem_Read_not_Write = 0. Advance to IF on mem_ready, otherwise hold.
- BRANCH: alu_src_a = 1, alu_src_b = 0, ALUop = SUB.
  - Taken when (BNE and !zero) or (BEQ and zero): pc_write_enable = 1, PC_Source = 1.
  - Next state is always IF.
- JUMP: pc_write_enable = 1, PC_Source = 2, then IF.
- HALT: halted = 1, no writes, self-loop.
- ERROR: error = 1, no writes, self-loop. Only reset exits either state.
- Wait counter:
  - Clears on entry to IF, MEM_READ or MEM_STORE.
  - Increments each cycle in those states while mem_ready = 0, saturating at all-ones.
  - When MEM_TIMEOUT != 0 and count == MEM_TIMEOUT - 1 with mem_ready = 0, next state is ERROR.
  - mem_ready = 1 on that same cycle wins: normal advance, no error.
- Unreachable state encodings -> RESET.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Enabled: adds outputs cycle_cnt[31:0] and retire_cnt[31:0].
  - Both clear on reset.
  - cycle_cnt increments every cycle not in RESET, HALT or ERROR.
  - retire_cnt increments on each transition into IF from ID (NOP), ALU_WB, MEM_WB, MEM_STORE, BRANCH or JUMP.
  - Both wrap modulo 2^32.
- Disabled: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings (4 bits, 14 states)
  - opcodes: NOP = 0, ADD = 1, ADDI = 2, LR = 3, SR = 4, BNE = 5, LI = 6, SUB = 7, BEQ = 8, JMP = 9, HALT = 15
  - PC_SELECT_*, ALU_SRC_*, DATA_SELECT_* and ALU_OP_* constants
- Sub-module ctrl_mem_wait: the wait counter and timeout compare, with one timeout output.

Test Plan:
- Reset, then ADD, mem_ready tied to 1 → IF, ID, R_EXE, ALU_WB; RegWrite = 1 exactly in cycle 4; IR_Write = 1 in cycle 1.
- LR with mem_ready low for 3 cycles in MEM_READ → state held 4 cycles; MemToReg = 1 and RegWrite = 1 one cycle after mem_ready.
- BEQ with zero = 1 → PC_Source = 1, pc_write_enable = 1. BEQ with zero = 0 → pc_write_enable = 0. BNE gives the inverse results.
- Opcode 12 → ERROR, error = 1, held 20 cycles. Reset low for one edge → RESET, with PC_Source = 3.
- mem_ready held low in IF, MEM_TIMEOUT = 12 → ERROR entered on edge 12. A repeat run with mem_ready rising in the 12th cycle → ID, with no error.
- HALT after 2 ADDs with CTRL_PERF_CNT_EN defined → halted = 1, retire_cnt = 2, cycle_cnt frozen.
